// File: rtl/prism_cfg_sequencer.sv
// Streams two-word configuration records into the PRISM latch loader and
// holds the load address/data until the loader has swept every latch enable.
module prism_cfg_sequencer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic        abort,
    output logic [5:0]  cfg_addr,
    output logic [31:0] cfg_data,
    output logic        cfg_latch_wr,
    output logic        cfg_debug_wr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rec_count
);

    localparam int HOLD = 2 * DEPTH + 1;
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_V = CW'(HOLD);
    localparam logic [CW-1:0] ONE_V = CW'(1);
    localparam logic [31:0] MSB_MASK = 32'hFFFF_FFFF >> (64 - WIDTH);
    localparam logic [5:0] ADDR_NONE = 6'h00;
    localparam logic [5:0] ADDR_MSB = 6'h14;
    localparam logic [5:0] ADDR_LOAD = 6'h10;

    typedef enum logic [2:0] {
        IDLE,
        MSB_SET,
        MSB_WR,
        WAIT_LSB,
        LSB_WR,
        SHIFT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic [5:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          latch_q, latch_d;
    logic          dbg_q, dbg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    rec_q, rec_d;
    logic          hs;

    // abort masks the handshake in the same cycle it is raised
    assign s_ready = ready_q & ~abort;
    assign hs = s_valid & s_ready;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ready_d = 1'b0;
        addr_d = ADDR_NONE;
        data_d = data_q;
        latch_d = 1'b0;
        dbg_d = 1'b0;
        done_d = 1'b0;
        rec_d = rec_q;

        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - ONE_V;
                if (hs) begin
                    state_d = MSB_SET;
                    data_d = s_data & MSB_MASK;
                end
            end
            MSB_SET: state_d = MSB_WR;
            MSB_WR: state_d = WAIT_LSB;
            WAIT_LSB: begin
                if (hs) begin
                    state_d = LSB_WR;
                    data_d = s_data;
                end
            end
            LSB_WR: begin
                // the load pulse is already out, so the hold starts regardless of abort
                cnt_d = HOLD_V;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q - ONE_V;
                if (cnt_q == ONE_V) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                    rec_d = rec_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            done_d = 1'b0;
            rec_d = rec_q;
        end

        unique case (state_d)
            IDLE: begin
                ready_d = (cnt_d == '0);
                data_d = '0;
            end
            MSB_SET: addr_d = ADDR_MSB;
            MSB_WR: begin
                addr_d = ADDR_MSB;
                latch_d = 1'b1;
            end
            WAIT_LSB: ready_d = 1'b1;
            LSB_WR: begin
                addr_d = ADDR_LOAD;
                dbg_d = 1'b1;
            end
            SHIFT: addr_d = ADDR_LOAD;
            default: ready_d = 1'b0;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ready_q <= 1'b1;
            addr_q <= ADDR_NONE;
            data_q <= '0;
            latch_q <= 1'b0;
            dbg_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rec_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ready_q <= ready_d;
            addr_q <= addr_d;
            data_q <= data_d;
            latch_q <= latch_d;
            dbg_q <= dbg_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rec_q <= rec_d;
        end
    end

    assign cfg_addr = addr_q;
    assign cfg_data = data_q;
    assign cfg_latch_wr = latch_q;
    assign cfg_debug_wr = dbg_q;
    assign busy = busy_q;
    assign done = done_q;
    assign rec_count = rec_q;

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Bench for prism_cfg_sequencer: directed record scenarios plus random stream
// traffic checked against a timestamp-based record model.
module tb_prism_cfg_sequencer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 64;
    localparam int DONE_OFS = 2 * DEPTH + 3;
    localparam logic [31:0] MASK = (WIDTH >= 64) ? 32'hFFFF_FFFF
                                 : ((32'h1 << (WIDTH - 32)) - 32'h1);

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        abort;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_latch_wr;
    logic        cfg_debug_wr;
    logic        busy;
    logic        done;
    logic [7:0]  rec_count;

    prism_cfg_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .abort(abort),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_latch_wr(cfg_latch_wr),
        .cfg_debug_wr(cfg_debug_wr),
        .busy(busy),
        .done(done),
        .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int msb_t, lsb_t, hold_end;
    int last_done, done_gap;
    logic [31:0] msb_w, lsb_w;
    logic [7:0] rec;
    logic exp_ready;
    logic last_hs;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs follow from how long ago each word of the record was taken.
    task automatic expect_cycle();
        int d;
        logic [5:0] ea;
        logic [31:0] ed;
        logic el, eg, eb, eo;
        ea = 6'h00; ed = 32'h0; el = 0; eg = 0; eb = 0; eo = 0;
        exp_ready = 0;
        if (lsb_t >= 0) begin
            d = cyc - lsb_t;
            if (d == 1) begin
                ea = 6'h10; ed = lsb_w; eg = 1; eb = 1;
            end else if (d < DONE_OFS) begin
                ea = 6'h10; ed = lsb_w; eb = 1;
            end else begin
                eo = 1;
                rec = rec + 8'd1;
                msb_t = -1;
                lsb_t = -1;
                exp_ready = (cyc >= hold_end);
            end
        end else if (msb_t >= 0) begin
            d = cyc - msb_t;
            ed = msb_w; eb = 1;
            if (d <= 2) ea = 6'h14;
            if (d == 2) el = 1;
            if (d >= 3) exp_ready = 1;
        end else begin
            exp_ready = (cyc >= hold_end);
        end
        check_eq("cfg_addr", 32'(cfg_addr), 32'(ea));
        check_eq("cfg_data", cfg_data, ed);
        check_eq("cfg_latch_wr", 32'(cfg_latch_wr), 32'(el));
        check_eq("cfg_debug_wr", 32'(cfg_debug_wr), 32'(eg));
        check_eq("busy", 32'(busy), 32'(eb));
        check_eq("done", 32'(done), 32'(eo));
        check_eq("rec_count", 32'(rec_count), 32'(rec));
    endtask

    task automatic tick();
        #1;
        check_eq("s_ready", 32'(s_ready), 32'(exp_ready & ~abort));
        last_hs = s_valid && exp_ready && !abort;
        if (abort) begin
            msb_t = -1;
            lsb_t = -1;
        end else if (last_hs) begin
            if (msb_t < 0) begin
                msb_t = cyc;
                msb_w = s_data & MASK;
            end else begin
                lsb_t = cyc;
                lsb_w = s_data;
                hold_end = cyc + DONE_OFS;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            if (last_done >= 0) done_gap = cyc - last_done;
            last_done = cyc;
        end
        expect_cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1; s_valid = 1; abort = 0; s_data = $urandom;
        repeat (n) @(posedge clk);
        #1;
        cyc++;
        rst = 0;
        s_valid = 0;
        msb_t = -1; lsb_t = -1; hold_end = 0; rec = 8'd0;
        expect_cycle();
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        s_valid = 1;
        s_data = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_hs && n < 300);
        check_eq("send_accepted", 32'(last_hs), 32'd1);
    endtask

    task automatic idle(input int n);
        s_valid = 0;
        repeat (n) tick();
    endtask

    initial begin
        int u, acc, r0;
        last_done = -1;
        done_gap = 0;
        do_reset(3);
        idle(2);

        send(32'hDEADBEEF);
        send(32'h12345678);
        idle(25);

        last_done = -1;
        for (int i = 0; i < 6; i++) begin
            send($urandom);
            send($urandom);
        end
        idle(25);
        check_eq("b2b_done_gap", 32'(done_gap), 32'(2 * DEPTH + 6));

        send($urandom);
        idle(50);
        send($urandom);
        idle(25);

        send($urandom);
        send($urandom);
        u = cyc - 1;
        repeat (5) tick();
        abort = 1;
        s_valid = 0;
        tick();
        abort = 0;
        send(32'hA5A5_0001);
        acc = cyc - 1;
        check_eq("abort_hold", 32'(acc - u), 32'(DONE_OFS));
        send(32'h5A5A_0002);
        idle(25);

        s_valid = 1;
        s_data = 32'hCAFE_F00D;
        abort = 1;
        tick();
        abort = 0;
        idle(4);

        r0 = int'(rec);
        for (int i = 0; i < 256; i++) begin
            send($urandom);
            send($urandom);
        end
        idle(25);
        check_eq("rec_wrap", 32'(rec_count), 32'(r0));

        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = $urandom;
            abort = ($urandom_range(0, 49) == 0);
            tick();
        end
        abort = 0;
        s_valid = 1;
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(0, 1) != 0);
            s_data = $urandom;
            abort = ($urandom_range(0, 99) == 0);
            tick();
        end
        abort = 0;
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prism_cfg_sequencer.md
# prism_cfg_sequencer

Sequencer that feeds the PRISM configuration latch loader from a ready/valid word stream, replacing software-timed bus writes. For each configuration record it takes two 32-bit words from the stream. It first writes the MSB word to the MSB config latch (address 0x14, latch write strobe). It then writes the LSB word with a load request (address 0x10, debug write pulse). Finally it holds the data bus stable until the loader has swept every latch enable. It sits between the boot/config source (SPI fetch or debug FIFO) and the loader's address/data/strobe inputs.

## Interface
- DEPTH, 8: number of latch entries swept by the loader per load; sets the hold length.
- WIDTH, 64: config word width; bits WIDTH-1:32 come from the MSB word; 33 ≤ WIDTH ≤ 64.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word; records arrive as MSB word first, then LSB word.
- s_ready  out  1  sequencer accepts s_data this cycle when s_valid & s_ready.
- abort  in  1  synchronous abort; drops the current record.
- cfg_addr  out  6  loader address: 0x00 neutral, 0x14 MSB latch, 0x10 load.
- cfg_data  out  32  loader data_in.
- cfg_latch_wr  out  1  MSB latch write strobe, one-cycle pulse.
- cfg_debug_wr  out  1  load request, one-cycle pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a record's sweep completes.
- rec_count  out  8  completed records since reset, wraps 255→0.

## Operation
- All outputs are registered. Reset values: s_ready=1, cfg_addr=0x00, cfg_data=0, both strobes=0, busy=0, done=0, rec_count=0, state=IDLE.
- The FSM has six states: IDLE, MSB_SET, MSB_WR, WAIT_LSB, LSB_WR, SHIFT.
- IDLE: s_ready=1, cfg_addr=0x00. A handshake captures the MSB word and moves to MSB_SET.
- MSB_SET: cfg_addr=0x14, cfg_data=MSB word, no strobe. Setup cycle. Next state is MSB_WR.
- MSB_WR: cfg_latch_wr=1 for exactly this cycle; address and data are unchanged. Next state is WAIT_LSB.
- WAIT_LSB: s_ready=1, cfg_addr=0x00, cfg_data still holds the MSB word. A handshake captures the LSB word and moves to LSB_WR. The wait is unbounded.
- LSB_WR: cfg_addr=0x10, cfg_data=LSB word, cfg_debug_wr=1 for exactly this cycle. Hold counter loads 2*DEPTH+1. Next state is SHIFT.
- SHIFT: cfg_addr=0x10, cfg_data=LSB word held, no strobes, s_ready=0. The counter decrements each cycle. At count 1 the FSM goes to IDLE, pulses done and increments rec_count.
- s_ready is 0 in MSB_SET, MSB_WR, LSB_WR and SHIFT. Words are never dropped or duplicated.
- abort has priority over every transition. On the next edge the FSM is in IDLE and outputs return to reset values, except rec_count, which holds. No done pulse is produced.
- An abort during SHIFT leaves the loader mid-sweep. The next record must not be issued until 2*DEPTH+1 cycles have elapsed from the LSB_WR cycle. The FSM enforces this by letting the hold counter keep running while in IDLE, with s_ready=0 until it reaches 0.
- abort and a handshake in the same cycle: abort wins and the word is not accepted (s_ready is forced low that cycle).
- rst mid-operation: immediate return to reset values on the next edge, counter cleared.

## Timing
- MSB word accepted at cycle T: MSB_SET at T+1, cfg_latch_wr=1 at T+2, WAIT_LSB from T+3.
- LSB word accepted at cycle U: cfg_debug_wr=1 at U+1, SHIFT from U+2 to U+2+2*DEPTH, done=1 at U+3+2*DEPTH.
- With the stream always valid, one record takes 2*DEPTH+6 cycles from MSB handshake to the next MSB handshake. That is 22 cycles at DEPTH=8.
- The hold of 2*DEPTH+1 cycles covers the loader's DEPTH SHIFT/WAIT pairs plus its registered latch enable.

## Test plan
- Reset state: hold rst for 3 cycles with s_valid=1 → all outputs at reset values, no handshake occurs during reset.
- Single record, DEPTH=8: MSB 0xDEADBEEF at T, LSB 0x12345678 at T+3. Check:
  - cfg_latch_wr pulses only at T+2 with addr 0x14 and data 0xDEADBEEF.
  - cfg_debug_wr pulses only at T+4 with addr 0x10 and data 0x12345678.
  - Data holds through T+21.
  - done pulses at T+22 and rec_count becomes 1.
- Back-to-back: stream of 6 records continuously valid → s_ready low during the busy states, 6 done pulses exactly 22 cycles apart, rec_count=6, every word seen exactly once on cfg_data.
- Stalled LSB: s_valid low for 50 cycles after the MSB word → FSM stays in WAIT_LSB, cfg_addr=0x00, no strobes, busy=1.
- Abort in SHIFT, 5 cycles after the debug pulse: FSM in IDLE next cycle with no done pulse. s_ready stays 0 for the remaining 12 hold cycles. The next MSB word is accepted only after that.
- Abort coincident with an MSB handshake → word not accepted, strobes stay 0. Also check rec_count wraps from 255 to 0 on the 256th record.
